vram_cpu_port: RTL

// - CPU-side VRAM access port. It is the write/read end of the plane memory that
//   the pixel pipeline fetches from.
// - Holds the plane write mask (6 planes: fg1..3, bg1..3) and the read-plane select.
// - Fans each CPU write out to every masked plane, one RAM cycle per plane.
//   CPU reads return the selected plane.
// - Shares one single-port VRAM with video fetch. Video always wins a cycle; the CPU is stalled via cpu_wait.

---
 rtl/vram_pkg.sv | 37 +++
 rtl/lsb_onehot_enc.sv | 22 ++
 rtl/vram_cpu_port.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/vram_pkg.sv
// Shared constants, types and helpers for the CPU-side VRAM plane port.
package vram_pkg;

  localparam int unsigned AW     = 13;
  localparam int unsigned PLANES = 6;
  localparam int unsigned PW     = 3;
  localparam int unsigned DW     = 8;
  localparam int unsigned RAW    = AW + PW;

  localparam logic [PW-1:0] PLANE_FG1 = 3'd0;
  localparam logic [PW-1:0] PLANE_FG2 = 3'd1;
  localparam logic [PW-1:0] PLANE_FG3 = 3'd2;
  localparam logic [PW-1:0] PLANE_BG1 = 3'd3;
  localparam logic [PW-1:0] PLANE_BG2 = 3'd4;
  localparam logic [PW-1:0] PLANE_BG3 = 3'd5;

  localparam logic [DW-1:0] RD_INVALID = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_ISS,
    ST_RD_WAIT
  } state_e;

  typedef struct packed {
    logic           we;
    logic [RAW-1:0] addr;
    logic [DW-1:0]  wdata;
  } ram_req_t;

  // rsel is one-based: 1..6 map onto planes fg1..bg3, anything else reads as invalid
  function automatic logic rsel_valid(input logic [PW-1:0] rsel);
    return (rsel >= PW'(PLANE_FG1 + 3'd1)) && (rsel <= PW'(PLANE_BG3 + 3'd1));
  endfunction

endpackage

// File: rtl/lsb_onehot_enc.sv
// Lowest-set-bit encoder: returns the index of the lowest pending plane.
module lsb_onehot_enc
  import vram_pkg::*;
(
  input  logic [PLANES-1:0] vec,
  output logic [PW-1:0]     idx_c,
  output logic              none_c
);

  // Scan from the top so the lowest set bit is the last one to win
  always_comb begin
    idx_c  = '0;
    none_c = 1'b1;
    for (int i = PLANES - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx_c  = PW'(i);
        none_c = 1'b0;
      end
    end
  end

endmodule

// File: rtl/vram_cpu_port.sv
// CPU write/read port of the plane VRAM; shares the single-port RAM with video
// fetch, which always wins the cycle.
module vram_cpu_port
  import vram_pkg::*;
(
  input  logic           clk_sys,
  input  logic           reset_n,
  input  logic           cpu_wr,
  input  logic           cpu_rd,
  input  logic [AW-1:0]  cpu_addr,
  input  logic [DW-1:0]  cpu_din,
  output logic [DW-1:0]  cpu_dout,
  output logic           cpu_wait,
  output logic           cpu_done,
  input  logic           wmask_we,
  input  logic           rsel_we,
  input  logic [7:0]     io_data,
  input  logic           vid_req,
  input  logic [AW-1:0]  vid_addr,
  input  logic [PW-1:0]  vid_plane,
  output logic [DW-1:0]  vid_data,
  output logic           vid_ack,
  output logic [RAW-1:0] ram_addr,
  output logic           ram_we,
  output logic [DW-1:0]  ram_wdata,
  input  logic [DW-1:0]  ram_rdata
);

  state_e            state_q, state_d;
  logic [PLANES-1:0] wmask_q;
  logic [PLANES-1:0] pend_q, pend_d;
  logic [PW-1:0]     rsel_q;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     data_q, data_d;
  logic [DW-1:0]     dout_d;
  logic              done_d, wait_d;
  logic [PW-1:0]     low_idx;
  logic              low_none;
  logic              rsel_ok;
  ram_req_t          seq_req, ram_req;
  logic              unused_io;

  assign unused_io = ^io_data[7:PLANES];
  assign rsel_ok   = rsel_valid(rsel_q);

  lsb_onehot_enc u_lsb_enc (
    .vec    (pend_q),
    .idx_c  (low_idx),
    .none_c (low_none)
  );

  // State register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state and sequencer datapath
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_wr) begin
          addr_d = cpu_addr;
          data_d = cpu_din;
          pend_d = wmask_q;
          if (wmask_q != '0) state_d = ST_WR;
        end else if (cpu_rd) begin
          addr_d = cpu_addr;
          if (rsel_ok) state_d = ST_RD_ISS;
        end
      end
      ST_WR: begin
        if (low_none) begin
          state_d = ST_IDLE;
        end else if (!vid_req) begin
          pend_d = pend_q & ~(PLANES'(1) << low_idx);
          if (pend_d == '0) state_d = ST_IDLE;
        end
      end
      ST_RD_ISS:  if (!vid_req) state_d = ST_RD_WAIT;
      ST_RD_WAIT: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Sequencer RAM request and next values of the registered CPU outputs
  always_comb begin
    seq_req       = '0;
    seq_req.addr  = {PW'(0), addr_q};
    seq_req.wdata = data_q;
    done_d        = 1'b0;
    dout_d        = cpu_dout;
    wait_d        = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (cpu_wr) begin
          done_d = (wmask_q == '0);
        end else if (cpu_rd && !rsel_ok) begin
          done_d = 1'b1;
          dout_d = RD_INVALID;
        end
      end
      ST_WR: begin
        seq_req.we   = !low_none;
        seq_req.addr = {low_idx, addr_q};
        done_d       = (state_d == ST_IDLE);
      end
      ST_RD_ISS: seq_req.addr = {PW'(rsel_q - PW'(1)), addr_q};
      ST_RD_WAIT: begin
        done_d = 1'b1;
        dout_d = ram_rdata;
      end
      default: ;
    endcase
  end

  // Video owns the RAM in any cycle it requests it
  always_comb begin
    ram_req = seq_req;
    if (vid_req) begin
      ram_req.we   = 1'b0;
      ram_req.addr = {vid_plane, vid_addr};
    end
  end

  assign ram_we    = ram_req.we;
  assign ram_addr  = ram_req.addr;
  assign ram_wdata = ram_req.wdata;
  assign vid_data  = vid_ack ? ram_rdata : '0;

  // Control registers, latched access and registered outputs
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wmask_q  <= '0;
      rsel_q   <= '0;
      pend_q   <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      cpu_dout <= '0;
      cpu_wait <= 1'b0;
      cpu_done <= 1'b0;
      vid_ack  <= 1'b0;
    end else begin
      if (wmask_we) wmask_q <= io_data[PLANES-1:0];
      if (rsel_we)  rsel_q  <= io_data[PW-1:0];
      pend_q   <= pend_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      cpu_dout <= dout_d;
      cpu_wait <= wait_d;
      cpu_done <= done_d;
      vid_ack  <= vid_req;
    end
  end

endmodule
